// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: forwarding selects, branch types, hazard FSM states
// and the forwarding-source helper used by the hazard controller.
package cpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } branch_type_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
  } stall_t;

  typedef struct packed {
    logic d;
    logic e;
    logic m;
    logic w;
  } flush_t;

  // MEM wins over WB because it holds the younger result for the same register.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [2:0] reg_write_m,
    input logic [4:0] rd_w,
    input logic [2:0] reg_write_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && reg_write_m != 3'd0 && rd_m != 5'd0 && rd_m == rs)
      sel = FWD_MEM;
    else if (used && reg_write_w != 3'd0 && rd_w != 5'd0 && rd_w == rs)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave):
// stage register fields in, stage-register enables/clears and forward selects out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [1:0]       RegReadD;
  logic             JalD;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       RegReadE;
  logic             MemToRegE;
  logic [2:0]       BranchTypeE;
  logic             JalrE;
  logic             PredE;
  logic             BrE;
  logic             TargetMatchE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic [2:0]       RegWriteM;
  logic [2:0]       RegWriteW;
  logic             DmemReqM;
  logic             DmemAckM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             FlushW;
  logic [1:0]       Forward1E;
  logic [1:0]       Forward2E;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MispredCnt;
  logic             MemTimeout;

  modport master (
    output Rs1D, Rs2D, RegReadD, JalD,
    output Rs1E, Rs2E, RdE, RegReadE, MemToRegE,
    output BranchTypeE, JalrE, PredE, BrE, TargetMatchE,
    output RdM, RdW, RegWriteM, RegWriteW, DmemReqM, DmemAckM,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushM, FlushW,
    input  Forward1E, Forward2E,
    input  BranchCnt, MispredCnt, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, RegReadD, JalD,
    input  Rs1E, Rs2E, RdE, RegReadE, MemToRegE,
    input  BranchTypeE, JalrE, PredE, BrE, TargetMatchE,
    input  RdM, RdW, RegWriteM, RegWriteW, DmemReqM, DmemAckM,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW,
    output Forward1E, Forward2E,
    output BranchCnt, MispredCnt, MemTimeout
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && count != '1)
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline: resolves load-use, jump,
// mispredict and data-memory-wait hazards and keeps branch statistics.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              mem_timeout;

  logic   mis;
  logic   lu;
  logic   mem_stall;
  logic   timeout_hit;
  logic   is_branch;
  stall_t stall;
  flush_t flush;

  // Hazard detection
  always_comb begin
    is_branch = (hz.BranchTypeE != NOBRANCH);
    mis = (is_branch && ((hz.PredE != hz.BrE) || (hz.BrE && !hz.TargetMatchE)))
          || hz.JalrE;
    lu  = hz.MemToRegE && (hz.RdE != 5'd0) &&
          ((hz.RegReadD[1] && hz.RdE == hz.Rs1D) ||
           (hz.RegReadD[0] && hz.RdE == hz.Rs2D));
    // The ack cycle itself is not stalled: the access completes and the
    // pipeline advances on that edge.
    mem_stall = (state == MEM_WAIT && !hz.DmemAckM) ||
                (state == RUN && hz.DmemReqM && !hz.DmemAckM);
    timeout_hit = (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1));
  end

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise an untaken path holds the old value and infers a latch.
  always_comb begin
    stall = '0;
    flush = '0;
    if (rst) begin
      flush = '1;
    end else if (mem_stall) begin
      stall   = '1;
      flush.w = 1'b1;
    end else if (mis) begin
      // A load-use seen in D is on the wrong path here and is discarded.
      flush.d = 1'b1;
      flush.e = 1'b1;
    end else if (lu) begin
      stall.f = 1'b1;
      stall.d = 1'b1;
      flush.e = 1'b1;
    end else if (hz.JalD) begin
      flush.d = 1'b1;
    end
  end

  assign hz.StallF = stall.f;
  assign hz.StallD = stall.d;
  assign hz.StallE = stall.e;
  assign hz.StallM = stall.m;
  assign hz.FlushD = flush.d;
  assign hz.FlushE = flush.e;
  assign hz.FlushM = flush.m;
  assign hz.FlushW = flush.w;

  // Forwarding is independent of stalls so a held EX instruction keeps its bypass.
  always_comb begin
    hz.Forward1E = FWD_RF;
    hz.Forward2E = FWD_RF;
    if (!rst) begin
      hz.Forward1E = fwd_sel(hz.RegReadE[1], hz.Rs1E, hz.RdM, hz.RegWriteM,
                             hz.RdW, hz.RegWriteW);
      hz.Forward2E = fwd_sel(hz.RegReadE[0], hz.Rs2E, hz.RdM, hz.RegWriteM,
                             hz.RdW, hz.RegWriteW);
    end
  end

  // Data-memory wait FSM with abandon-on-timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hz.DmemReqM && !hz.DmemAckM) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.DmemAckM) begin
            state <= RUN;
          end else if (timeout_hit) begin
            state       <= RUN;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign hz.MemTimeout = mem_timeout;

  // Statistics only count instructions that actually leave EX this cycle.
  logic inc_branch;
  logic inc_mis;

  assign inc_branch = !mem_stall && (is_branch || hz.JalrE);
  assign inc_mis    = !mem_stall && mis;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_branch),
    .count (hz.BranchCnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_mis),
    .count (hz.MispredCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares the controller outputs.
module tb_hazard_ctrl;

  localparam int CNT_W       = 2;
  localparam int MEM_TIMEOUT = 4;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d;
    logic [4:0] rs2d;
    logic [1:0] rrd;
    logic       jald;
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] rde;
    logic [1:0] rre;
    logic       mtre;
    logic [2:0] bte;
    logic       jalre;
    logic       prede;
    logic       bre;
    logic       tme;
    logic [4:0] rdm;
    logic [4:0] rdw;
    logic [2:0] rwm;
    logic [2:0] rww;
    logic       req;
    logic       ack;
  } stim_t;

  // Packed response: {StallF,D,E,M, FlushD,E,M,W, Fwd1, Fwd2, BranchCnt, MispredCnt, MemTimeout}
  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [16:0] ex(input logic [3:0] st, input logic [3:0] fl,
                                     input logic [1:0] f1, input logic [1:0] f2,
                                     input logic [1:0] bc, input logic [1:0] mc,
                                     input logic t);
    return {st, fl, f1, f2, bc, mc, t};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got stall=%b flush=%b fwd1=%b fwd2=%b bcnt=%0d mcnt=%0d tmo=%b, expected stall=%b flush=%b fwd1=%b fwd2=%b bcnt=%0d mcnt=%0d tmo=%b",
               name, act[16:13], act[12:9], act[8:7], act[6:5], act[4:3], act[2:1], act[0],
               exp_v[16:13], exp_v[12:9], exp_v[8:7], exp_v[6:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
    end
  endtask

  task automatic apply(input stim_t s);
    rst             = s.rst;
    hz.Rs1D         = s.rs1d;
    hz.Rs2D         = s.rs2d;
    hz.RegReadD     = s.rrd;
    hz.JalD         = s.jald;
    hz.Rs1E         = s.rs1e;
    hz.Rs2E         = s.rs2e;
    hz.RdE          = s.rde;
    hz.RegReadE     = s.rre;
    hz.MemToRegE    = s.mtre;
    hz.BranchTypeE  = s.bte;
    hz.JalrE        = s.jalre;
    hz.PredE        = s.prede;
    hz.BrE          = s.bre;
    hz.TargetMatchE = s.tme;
    hz.RdM          = s.rdm;
    hz.RdW          = s.rdw;
    hz.RegWriteM    = s.rwm;
    hz.RegWriteW    = s.rww;
    hz.DmemReqM     = s.req;
    hz.DmemAckM     = s.ack;
  endtask

  // One pipeline cycle: drive just after the edge, queue the expected response.
  task automatic cyc(input string name, input stim_t s, input logic [16:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    apply(s);
    item.name = name;
    item.v    = e;
    sb.push_back(item);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.name,
            {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
             hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW,
             hz.Forward1E, hz.Forward2E, hz.BranchCnt, hz.MispredCnt, hz.MemTimeout},
            e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    apply(s);

    cyc("reset", s, ex(4'b0000, 4'b1111, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0;
    cyc("idle", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));

    // Load-use
    s = '0; s.mtre = 1'b1; s.rde = 5'd5; s.rrd = 2'b10; s.rs1d = 5'd5;
    cyc("lu_rs1", s, ex(4'b1100, 4'b0100, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0; s.rs1e = 5'd5; s.rre = 2'b10; s.rdw = 5'd5; s.rww = 3'd1;
    cyc("lu_fwd_wb", s, ex(4'b0000, 4'b0000, 2'b01, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0; s.mtre = 1'b1; s.rde = 5'd9; s.rrd = 2'b01; s.rs2d = 5'd9;
    cyc("lu_rs2", s, ex(4'b1100, 4'b0100, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0; s.mtre = 1'b1; s.rde = 5'd0; s.rrd = 2'b11;
    cyc("lu_x0", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0; s.mtre = 1'b1; s.rde = 5'd5; s.rrd = 2'b01; s.rs1d = 5'd5; s.rs2d = 5'd6;
    cyc("lu_unused", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));

    // Mispredict priority and statistics
    s = '0; s.mtre = 1'b1; s.rde = 5'd5; s.rrd = 2'b10; s.rs1d = 5'd5;
    s.bte = 3'd1; s.prede = 1'b0; s.bre = 1'b1; s.tme = 1'b1;
    cyc("mis_over_lu", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0;
    cyc("cnt_after_mis", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    s = '0; s.bte = 3'd1; s.prede = 1'b1; s.bre = 1'b1; s.tme = 1'b1;
    cyc("br_ok", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    s = '0;
    cyc("cnt_after_ok", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd2, 2'd1, 1'b0));
    s = '0; s.bte = 3'd5; s.prede = 1'b1; s.bre = 1'b1; s.tme = 1'b0;
    cyc("br_tgt_miss", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd2, 2'd1, 1'b0));
    s = '0; s.jald = 1'b1;
    cyc("jal_d", s, ex(4'b0000, 4'b1000, 2'b00, 2'b00, 2'd3, 2'd2, 1'b0));
    s = '0; s.jalre = 1'b1; s.jald = 1'b1;
    cyc("jalr_e", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd3, 2'd2, 1'b0));
    s = '0;
    cyc("cnt_sat_branch", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));
    s = '0; s.bte = 3'd1; s.prede = 1'b1; s.bre = 1'b0; s.tme = 1'b1;
    cyc("br_pred_nt", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));
    s = '0; s.mtre = 1'b1; s.rde = 5'd5; s.rrd = 2'b10; s.rs1d = 5'd5; s.jald = 1'b1;
    cyc("lu_over_jal", s, ex(4'b1100, 4'b0100, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));

    // Forwarding
    s = '0; s.rdm = 5'd7; s.rdw = 5'd7; s.rwm = 3'd1; s.rww = 3'd1; s.rs2e = 5'd7; s.rre = 2'b01;
    cyc("fwd_mem", s, ex(4'b0000, 4'b0000, 2'b00, 2'b10, 2'd3, 2'd3, 1'b0));
    s.rdm = 5'd0;
    cyc("fwd_wb", s, ex(4'b0000, 4'b0000, 2'b00, 2'b01, 2'd3, 2'd3, 1'b0));
    s.rdm = 5'd7; s.rre = 2'b00;
    cyc("fwd_unused", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));
    s = '0; s.rdm = 5'd7; s.rwm = 3'd0; s.rdw = 5'd7; s.rww = 3'd2; s.rs2e = 5'd7; s.rre = 2'b01;
    cyc("fwd_m_nowrite", s, ex(4'b0000, 4'b0000, 2'b00, 2'b01, 2'd3, 2'd3, 1'b0));
    s = '0; s.rs1e = 5'd3; s.rs2e = 5'd3; s.rre = 2'b11;
    s.rdm = 5'd3; s.rwm = 3'd1; s.rdw = 5'd3; s.rww = 3'd1;
    cyc("fwd_both", s, ex(4'b0000, 4'b0000, 2'b10, 2'b10, 2'd3, 2'd3, 1'b0));

    s = '0; s.rst = 1'b1;
    cyc("reset2", s, ex(4'b0000, 4'b1111, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0;
    cyc("idle2", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));

    // Memory wait: three stalled cycles with a mispredict parked in EX
    s = '0; s.req = 1'b1; s.ack = 1'b0;
    s.bte = 3'd1; s.prede = 1'b0; s.bre = 1'b1; s.tme = 1'b1;
    s.rdm = 5'd4; s.rwm = 3'd1; s.rs1e = 5'd4; s.rre = 2'b10;
    cyc("mem_wait1", s, ex(4'b1111, 4'b0001, 2'b10, 2'b00, 2'd0, 2'd0, 1'b0));
    cyc("mem_wait2", s, ex(4'b1111, 4'b0001, 2'b10, 2'b00, 2'd0, 2'd0, 1'b0));
    cyc("mem_wait3", s, ex(4'b1111, 4'b0001, 2'b10, 2'b00, 2'd0, 2'd0, 1'b0));
    s.ack = 1'b1;
    cyc("mem_ack", s, ex(4'b0000, 4'b1100, 2'b10, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0;
    cyc("cnt_after_ack", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    s = '0; s.req = 1'b1; s.ack = 1'b1;
    cyc("req_ack_same", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));

    // Timeout: entry cycle plus MEM_TIMEOUT wait cycles, then sticky flag
    s = '0; s.req = 1'b1; s.ack = 1'b0;
    cyc("tmo_enter", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    for (int i = 0; i < MEM_TIMEOUT; i++)
      cyc($sformatf("tmo_wait%0d", i), s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    s = '0;
    cyc("tmo_flag", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b1));
    cyc("tmo_sticky", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd1, 2'd1, 1'b1));

    // Reset in the middle of a wait
    s = '0; s.req = 1'b1; s.ack = 1'b0; s.bte = 3'd1; s.prede = 1'b0; s.bre = 1'b1; s.tme = 1'b1;
    cyc("mw_again", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 2'd1, 2'd1, 1'b1));
    cyc("mw_again2", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 2'd1, 2'd1, 1'b1));
    s.rst = 1'b1;
    cyc("rst_mid_wait", s, ex(4'b0000, 4'b1111, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    s = '0;
    cyc("post_rst", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));

    // Five mispredicts saturate a 2-bit counter at 3
    s = '0; s.jalre = 1'b1;
    cyc("mis_sat0", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd0, 2'd0, 1'b0));
    cyc("mis_sat1", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd1, 2'd1, 1'b0));
    cyc("mis_sat2", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd2, 2'd2, 1'b0));
    cyc("mis_sat3", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));
    cyc("mis_sat4", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));
    s = '0;
    cyc("mis_sat", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 2'd3, 2'd3, 1'b0));

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
